clk_div_multi: RTL and testbench
================================

# clk_div_multi

Parametrised multi-channel clock divider. Each of `NCH` independent channels divides `clk` by a programmable integer divisor. For each channel it produces a near-50% duty divided waveform and a one-cycle tick marking the start of each period. Divisor changes are glitch-free, and a global sync realigns the phases of all channels. The block is the general successor to the fixed divide-by-2/3 divider and feeds clock-enable and strobe consumers in the `clk` domain; it generates no derived clocks.

## Interface
- `NCH`, 4, number of channels (1..16)
- `CW`, 8, divisor width per channel (2..16)
- `DEF_DIV`, 2, reset divisor for every channel (0..2^CW-1)

- `clk` in 1 — sole clock, all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `en_i` in NCH — per-channel enable, level
- `div_i` in NCH*CW — divisor; channel k uses bits [k*CW +: CW]
- `load_i` in NCH — per-channel one-cycle strobe that captures `div_i` slice k
- `sync_i` in 1 — one-cycle strobe that restarts all enabled channels in phase
- `out_o` out NCH — divided waveform, registered
- `tick_o` out NCH — one-cycle pulse in the first cycle of each period, registered
- `pend_o` out NCH — a loaded divisor is waiting for the period boundary

## Operation
- Per-channel state: active divisor `D`, shadow divisor `S`, pending flag, counter `cnt` (CW bits).
- Definitions: `H = ceil(D/2)`. A channel is "running" when `en_i` is 1 and `D >= 2`.
- Running channel behaviour:
  - `cnt` counts 0..D-1 and wraps to 0.
  - `out_o = (cnt < H)`, giving H cycles high and D-H cycles low. Duty is exactly 50% for even D; for odd D the high phase is one cycle longer.
  - `tick_o = (cnt == 0)`.
- `D == 1`, enabled: `out_o` held 1; `tick_o` 1 every cycle.
- `D == 0`, or `en_i` low: `cnt` held at 0; `out_o` 0; `tick_o` 0.
- Enable rising (en was 0 last cycle, is 1 now): the period starts fresh with `cnt = 0`, `out_o = 1`, `tick_o = 1`.
- `load_i[k]` while channel k is running:
  - `S <= div_i` slice and pending <= 1.
  - At the next wrap (the edge where `cnt == D-1`), `D <= S`, pending <= 0, and the new period starts with the new D.
  - The current period always completes; no runt pulse is produced.
- `load_i[k]` while channel k is not running: `D <= div_i` slice immediately; pending stays 0.
- Load on the same edge as a wrap: the new value takes effect at that wrap (bypasses the shadow); pending stays 0.
- A second load before the boundary overwrites `S`; last write wins.
- `sync_i` behaviour:
  - Every enabled channel restarts: `cnt <= 0`, `out_o <= 1`, `tick_o <= 1`.
  - Any pending `S` is applied immediately.
  - With `load_i` on the same edge, the new `div_i` slice is applied immediately.
  - Disabled channels are unaffected.
- `rst` (also mid-period) restores, at the next edge:
  - `D = DEF_DIV`, `S = DEF_DIV`
  - `cnt = 0`
  - `out_o = 0`, `tick_o = 0`, `pend_o = 0`
  - The previous enable state is cleared, so an `en_i` already high counts as a fresh enable after reset.
- Priority (high to low): `rst` > `sync_i` > enable rising > wrap/load > count.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- `en_i` rises before edge t → after t: `out_o = 1`, `tick_o = 1`.
- `en_i` falls before edge t → after t: `out_o = 0`, `tick_o = 0`, `cnt = 0`.
- `load_i` at edge t, channel running → `pend_o = 1` after t; new D visible at the first wrap at or after t+1.
- `sync_i` at edge t → all enabled channels show `tick_o = 1` in the cycle after t, phase-aligned.
- Period length equals D exactly, including across divisor changes.

## Test plan
- **Reset values:** hold `rst` 3 cycles with `en_i` = all 1s → `out_o`, `tick_o`, `pend_o` all 0. On release, channels at `DEF_DIV` = 2 toggle 1,0,1,0 and tick every 2nd cycle.
- **Odd and even divisors:** ch0 D=3, ch1 D=4, enabled together → ch0 `out_o` 1,1,0 repeating, ticks every 3 cycles; ch1 `out_o` 1,1,0,0, ticks every 4 cycles. Check for 24 cycles.
- **Mid-period load:** ch0 running at D=5; load 2 at `cnt` = 1 → `pend_o` = 1. The period completes as 1,1,1,0,0, then 1,0 repeats; `pend_o` clears at the wrap. Repeat with the load on the wrap edge → the new D takes effect immediately.
- **Enable toggle:** drop ch2 `en_i` mid-high phase → `out_o` = 0 on the next cycle. Re-enable → tick plus a fresh full high phase.
- **Sync alignment:** ch0..3 running at D = 3, 5, 6, 7 with random phases; pulse `sync_i` → all four ticks coincide on the next cycle and periods are exact afterwards. A disabled channel stays low.
- **Degenerate divisors:** D=0 → `out_o` 0 with no ticks. D=1 → `out_o` 1 with a tick every cycle. Load D=2^CW-1 → `out_o` high 128 cycles, low 127.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel divides clk by its own divisor and produces a near-50% duty
// enable waveform plus a start-of-period tick. Divisor updates are staged in a
// shadow register and committed at the period boundary so no runt period occurs.
module clk_div_multi #(
    parameter int NCH     = 4,
    parameter int CW      = 8,
    parameter int DEF_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    en_i,
    input  logic [NCH*CW-1:0] div_i,
    input  logic [NCH-1:0]    load_i,
    input  logic              sync_i,
    output logic [NCH-1:0]    out_o,
    output logic [NCH-1:0]    tick_o,
    output logic [NCH-1:0]    pend_o
);

    localparam logic [CW-1:0] DEF_D = CW'(DEF_DIV);
    localparam logic [CW-1:0] TWO   = CW'(2);

    logic [CW-1:0]  d_q   [NCH];
    logic [CW-1:0]  d_d   [NCH];
    logic [CW-1:0]  s_q   [NCH];
    logic [CW-1:0]  s_d   [NCH];
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [CW:0]    half  [NCH];
    logic [NCH-1:0] pend_q,    pend_d;
    logic [NCH-1:0] out_q,     out_d;
    logic [NCH-1:0] tick_q,    tick_d;
    logic [NCH-1:0] en_prev_q, en_prev_d;

    // Per-channel next-state: sync > enable rising > wrap/load > count
    always_comb begin
        for (int unsigned k = 0; k < NCH; k++) begin
            d_d[k]       = d_q[k];
            s_d[k]       = s_q[k];
            cnt_d[k]     = cnt_q[k];
            pend_d[k]    = pend_q[k];
            en_prev_d[k] = en_i[k];
            half[k]      = '0;
            out_d[k]     = 1'b0;
            tick_d[k]    = 1'b0;

            if (!en_i[k] || (!sync_i && en_prev_q[k] && (d_q[k] < TWO))) begin
                // Not running: hold count, commit any staged divisor, loads apply at once
                cnt_d[k]  = '0;
                pend_d[k] = 1'b0;
                if (pend_q[k]) d_d[k] = s_q[k];
                if (load_i[k]) d_d[k] = div_i[k*CW +: CW];
            end else if (sync_i || !en_prev_q[k]) begin
                // Restart in phase; staged or same-edge divisor takes effect now
                cnt_d[k]  = '0;
                pend_d[k] = 1'b0;
                if (pend_q[k]) d_d[k] = s_q[k];
                if (load_i[k]) d_d[k] = div_i[k*CW +: CW];
            end else if (cnt_q[k] == CW'(d_q[k] - 1'b1)) begin
                // Period boundary: a load on this edge bypasses the shadow
                cnt_d[k]  = '0;
                pend_d[k] = 1'b0;
                if (pend_q[k]) d_d[k] = s_q[k];
                if (load_i[k]) d_d[k] = div_i[k*CW +: CW];
            end else begin
                cnt_d[k] = cnt_q[k] + 1'b1;
                if (load_i[k]) begin
                    s_d[k]    = div_i[k*CW +: CW];
                    pend_d[k] = 1'b1;
                end
            end

            // Outputs are derived from the next state so they register cleanly
            half[k] = ({1'b0, d_d[k]} + 1'b1) >> 1;
            if (en_i[k] && (d_d[k] != '0)) begin
                out_d[k]  = ({1'b0, cnt_d[k]} < half[k]);
                tick_d[k] = (cnt_d[k] == '0);
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NCH; k++) begin
                d_q[k]   <= DEF_D;
                s_q[k]   <= DEF_D;
                cnt_q[k] <= '0;
            end
            pend_q    <= '0;
            out_q     <= '0;
            tick_q    <= '0;
            en_prev_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                d_q[k]   <= d_d[k];
                s_q[k]   <= s_d[k];
                cnt_q[k] <= cnt_d[k];
            end
            pend_q    <= pend_d;
            out_q     <= out_d;
            tick_q    <= tick_d;
            en_prev_q <= en_prev_d;
        end
    end

    assign out_o  = out_q;
    assign tick_o = tick_q;
    assign pend_o = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed testbench for clk_div_multi (NCH=4, CW=8, DEF_DIV=2).
module tb_clk_div_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en_i;
    logic [31:0] div_i;
    logic [3:0]  load_i;
    logic        sync_i;
    logic [3:0]  out_o;
    logic [3:0]  tick_o;
    logic [3:0]  pend_o;

    int checks = 0;
    int errors = 0;

    clk_div_multi #(.NCH(4), .CW(8), .DEF_DIV(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en_i),
        .div_i  (div_i),
        .load_i (load_i),
        .sync_i (sync_i),
        .out_o  (out_o),
        .tick_o (tick_o),
        .pend_o (pend_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en_i = '0; load_i = '0; sync_i = 1'b0; div_i = '0;
        step();
        rst = 1'b0;
    endtask

    // Expected waveform for a channel at offset i into a period of length d
    function automatic logic exp_out(input int i, input int d);
        return (i % d) < ((d + 1) / 2);
    endfunction

    function automatic logic exp_tick(input int i, input int d);
        return (i % d) == 0;
    endfunction

    initial begin
        int dv [4];
        logic [3:0] eo, et;

        // Reset values with enables held high
        rst = 1'b1; en_i = 4'hF; load_i = '0; sync_i = 1'b0; div_i = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_out",  out_o,  0);
            chk("rst_tick", tick_o, 0);
            chk("rst_pend", pend_o, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("def_out",  out_o,  (i % 2 == 0) ? 4'hF : 4'h0);
            chk("def_tick", tick_o, (i % 2 == 0) ? 4'hF : 4'h0);
        end

        // Odd and even divisors: ch0 D=3, ch1 D=4
        do_reset();
        div_i = {8'd0, 8'd0, 8'd4, 8'd3}; load_i = 4'b0011;
        step();
        load_i = '0; en_i = 4'b0011;
        for (int i = 0; i < 24; i++) begin
            step();
            eo = {2'b00, exp_out(i, 4), exp_out(i, 3)};
            et = {2'b00, exp_tick(i, 4), exp_tick(i, 3)};
            chk("oe_out",  out_o,  eo);
            chk("oe_tick", tick_o, et);
        end

        // Mid-period load: D=5, load 2 at cnt=1
        do_reset();
        div_i = 32'd5; load_i = 4'b0001;
        step();
        load_i = '0; en_i = 4'b0001;
        step(); chk("ml_c0_out", out_o, 4'b0001); chk("ml_c0_tick", tick_o, 4'b0001);
        step(); chk("ml_c1_out", out_o, 4'b0001); chk("ml_c1_tick", tick_o, 4'b0000);
        div_i = 32'd2; load_i = 4'b0001;
        step(); chk("ml_c2_out", out_o, 4'b0001); chk("ml_c2_pend", pend_o, 4'b0001);
        load_i = '0;
        step(); chk("ml_c3_out", out_o, 4'b0000); chk("ml_c3_pend", pend_o, 4'b0001);
        step(); chk("ml_c4_out", out_o, 4'b0000); chk("ml_c4_pend", pend_o, 4'b0001);
        step(); chk("ml_wrap_out", out_o, 4'b0001); chk("ml_wrap_tick", tick_o, 4'b0001);
        chk("ml_wrap_pend", pend_o, 4'b0000);
        step(); chk("ml_d2_out", out_o, 4'b0000); chk("ml_d2_tick", tick_o, 4'b0000);
        // Load coinciding with the wrap edge of D=2
        div_i = 32'd4; load_i = 4'b0001;
        step(); chk("lw_out", out_o, 4'b0001); chk("lw_tick", tick_o, 4'b0001);
        chk("lw_pend", pend_o, 4'b0000);
        load_i = '0;
        for (int i = 1; i < 9; i++) begin
            step();
            chk("lw_d4_out",  out_o,  {3'b000, exp_out(i, 4)});
            chk("lw_d4_tick", tick_o, {3'b000, exp_tick(i, 4)});
        end

        // Enable toggle on ch2 with D=6
        do_reset();
        div_i = {8'd0, 8'd6, 8'd0, 8'd0}; load_i = 4'b0100;
        step();
        load_i = '0; en_i = 4'b0100;
        step(); chk("et_c0_out", out_o, 4'b0100); chk("et_c0_tick", tick_o, 4'b0100);
        step(); chk("et_c1_out", out_o, 4'b0100);
        en_i = '0;
        step(); chk("et_off_out", out_o, 4'b0000); chk("et_off_tick", tick_o, 4'b0000);
        en_i = 4'b0100;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("et_re_out",  out_o,  {1'b0, exp_out(i, 6), 2'b00});
            chk("et_re_tick", tick_o, {1'b0, exp_tick(i, 6), 2'b00});
        end

        // Sync alignment: D = 3,5,6,7 started at staggered phases
        do_reset();
        dv = '{3, 5, 6, 7};
        div_i = {8'd7, 8'd6, 8'd5, 8'd3}; load_i = 4'hF;
        step();
        load_i = '0;
        en_i = 4'b0001; step();
        en_i = 4'b0011; step(); step();
        en_i = 4'b0111; step(); step(); step();
        en_i = 4'b1111; step(); step();
        sync_i = 1'b1;
        step(); chk("sy_out", out_o, 4'hF); chk("sy_tick", tick_o, 4'hF);
        sync_i = 1'b0;
        for (int i = 1; i < 22; i++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                eo[k] = exp_out(i, dv[k]);
                et[k] = exp_tick(i, dv[k]);
            end
            chk("sy_run_out",  out_o,  eo);
            chk("sy_run_tick", tick_o, et);
        end
        en_i = 4'b0111;
        step(); chk("sy_dis_out", out_o[3], 1'b0);
        step();
        sync_i = 1'b1;
        step(); chk("sy2_out", out_o, 4'b0111); chk("sy2_tick", tick_o, 4'b0111);
        sync_i = 1'b0;
        for (int i = 1; i < 10; i++) begin
            step();
            for (int k = 0; k < 3; k++) begin
                eo[k] = exp_out(i, dv[k]);
                et[k] = exp_tick(i, dv[k]);
            end
            eo[3] = 1'b0; et[3] = 1'b0;
            chk("sy2_run_out",  out_o,  eo);
            chk("sy2_run_tick", tick_o, et);
        end

        // Degenerate divisors: ch0 D=0, ch1 D=1, then ch0 D=255
        do_reset();
        div_i = {8'd0, 8'd0, 8'd1, 8'd0}; load_i = 4'b0011;
        step();
        load_i = '0; en_i = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("dg_out",  out_o,  4'b0010);
            chk("dg_tick", tick_o, 4'b0010);
        end
        div_i = {8'd0, 8'd0, 8'd1, 8'd255}; load_i = 4'b0001;
        step();
        load_i = '0;
        chk("max_c0_out",  out_o,  4'b0011);
        chk("max_c0_tick", tick_o, 4'b0011);
        chk("max_c0_pend", pend_o, 4'b0000);
        for (int i = 1; i < 257; i++) begin
            step();
            chk("max_out",  out_o,  {2'b00, 1'b1, exp_out(i, 255)});
            chk("max_tick", tick_o, {2'b00, 1'b1, exp_tick(i, 255)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
